// File: rtl/decode_stage.sv
// N-wide RV32I decode stage with a registered valid/ready output slot, flush and lane counter.
// Optional feature: define DECODE_MULDIV_EN to decode RV32M (funct7=0000001) as muldiv.
module decode_stage #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int CTRL_W    = 11
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XLEN-1:0]             in_pc,
  input  logic [NUM_LANES*32-1:0]     in_inst,
  input  logic [NUM_LANES-1:0]        in_lane_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_lane_valid,
  output logic [NUM_LANES*XLEN-1:0]   out_pc,
  output logic [NUM_LANES*5-1:0]      out_rd,
  output logic [NUM_LANES*5-1:0]      out_rs1,
  output logic [NUM_LANES*5-1:0]      out_rs2,
  output logic [NUM_LANES*3-1:0]      out_funct3,
  output logic [NUM_LANES*7-1:0]      out_funct7,
  output logic [NUM_LANES*XLEN-1:0]   out_imm,
  output logic [NUM_LANES*CTRL_W-1:0] out_ctrl,
  output logic [31:0]                 decoded_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int B_REG_WRITE  = 0;
  localparam int B_ALU_SRC    = 1;
  localparam int B_MEM_WRITE  = 2;
  localparam int B_ALU_OP     = 3;
  localparam int B_MEM_TO_REG = 5;
  localparam int B_MEM_READ   = 6;
  localparam int B_BRANCH     = 7;
  localparam int B_JUMP       = 8;
  localparam int B_ILLEGAL    = 9;
  localparam int B_MULDIV     = 10;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [31:0] inst);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (inst[6:0])
      OP_R: begin
        if (inst[31:25] == 7'b0000000 || inst[31:25] == 7'b0100000) begin
          c[B_REG_WRITE]       = 1'b1;
          c[B_ALU_OP +: 2]     = 2'b10;
        end
`ifdef DECODE_MULDIV_EN
        else if (inst[31:25] == 7'b0000001) begin
          c[B_REG_WRITE]       = 1'b1;
          c[B_ALU_OP +: 2]     = 2'b10;
          c[B_MULDIV]          = 1'b1;
        end
`endif
        else begin
          c[B_ILLEGAL]         = 1'b1;
        end
      end
      OP_IMM: begin
        c[B_REG_WRITE]   = 1'b1;
        c[B_ALU_SRC]     = 1'b1;
        c[B_ALU_OP +: 2] = 2'b11;
      end
      OP_LOAD: begin
        c[B_REG_WRITE]  = 1'b1;
        c[B_ALU_SRC]    = 1'b1;
        c[B_MEM_READ]   = 1'b1;
        c[B_MEM_TO_REG] = 1'b1;
      end
      OP_STORE: begin
        c[B_ALU_SRC]   = 1'b1;
        c[B_MEM_WRITE] = 1'b1;
      end
      OP_BRANCH: begin
        c[B_BRANCH]      = 1'b1;
        c[B_ALU_OP +: 2] = 2'b01;
      end
      OP_JAL: begin
        c[B_REG_WRITE] = 1'b1;
        c[B_JUMP]      = 1'b1;
      end
      OP_JALR: begin
        c[B_REG_WRITE] = 1'b1;
        c[B_JUMP]      = 1'b1;
        c[B_ALU_SRC]   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        c[B_REG_WRITE] = 1'b1;
        c[B_ALU_SRC]   = 1'b1;
      end
      default: c[B_ILLEGAL] = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so rename never sees them.
    if (inst[11:7] == 5'd0) c[B_REG_WRITE] = 1'b0;
    return c;
  endfunction

  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] inst);
    logic [31:0] imm32;
    imm32 = '0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {inst[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
    return XLEN'($signed(imm32));
  endfunction

  logic [NUM_LANES*XLEN-1:0]   dec_pc;
  logic [NUM_LANES*5-1:0]      dec_rd;
  logic [NUM_LANES*5-1:0]      dec_rs1;
  logic [NUM_LANES*5-1:0]      dec_rs2;
  logic [NUM_LANES*3-1:0]      dec_funct3;
  logic [NUM_LANES*7-1:0]      dec_funct7;
  logic [NUM_LANES*XLEN-1:0]   dec_imm;
  logic [NUM_LANES*CTRL_W-1:0] dec_ctrl;
  logic [31:0]                 lane_pop;
  logic                        load;
  logic                        fire;

  assign in_ready = reset_n && !flush && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  always_comb begin
    dec_pc     = '0;
    dec_rd     = '0;
    dec_rs1    = '0;
    dec_rs2    = '0;
    dec_funct3 = '0;
    dec_funct7 = '0;
    dec_imm    = '0;
    dec_ctrl   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dec_pc[XLEN*i +: XLEN] = in_pc + XLEN'(32'(4 * i));
      dec_funct3[3*i +: 3]   = in_inst[32*i+12 +: 3];
      dec_funct7[7*i +: 7]   = in_inst[32*i+25 +: 7];
      // Invalid lanes carry no register or control side effects downstream.
      if (in_lane_valid[i]) begin
        dec_rd[5*i +: 5]           = in_inst[32*i+7 +: 5];
        dec_rs1[5*i +: 5]          = in_inst[32*i+15 +: 5];
        dec_rs2[5*i +: 5]          = in_inst[32*i+20 +: 5];
        dec_imm[XLEN*i +: XLEN]    = decode_imm(in_inst[32*i +: 32]);
        dec_ctrl[CTRL_W*i +: CTRL_W] = decode_ctrl(in_inst[32*i +: 32]);
      end
    end
  end

  always_comb begin
    lane_pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_pop = lane_pop + 32'(out_lane_valid[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      out_pc         <= '0;
      out_rd         <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_funct3     <= '0;
      out_funct7     <= '0;
      out_imm        <= '0;
      out_ctrl       <= '0;
      decoded_count  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (fire) decoded_count <= decoded_count + lane_pop;
      if (load) begin
        out_valid      <= |in_lane_valid;
        out_lane_valid <= in_lane_valid;
        out_pc         <= dec_pc;
        out_rd         <= dec_rd;
        out_rs1        <= dec_rs1;
        out_rs2        <= dec_rs2;
        out_funct3     <= dec_funct3;
        out_funct7     <= dec_funct7;
        out_imm        <= dec_imm;
        out_ctrl       <= dec_ctrl;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage against a table-driven RV32I decode model.
// Honours DECODE_MULDIV_EN the same way the design does.
module tb_decode_stage;

  localparam int NL = 2;
  localparam int XL = 32;
  localparam int CW = 11;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XL-1:0]      in_pc;
  logic [NL*32-1:0]   in_inst;
  logic [NL-1:0]      in_lane_valid;
  logic               out_valid;
  logic               out_ready;
  logic [NL-1:0]      out_lane_valid;
  logic [NL*XL-1:0]   out_pc;
  logic [NL*5-1:0]    out_rd;
  logic [NL*5-1:0]    out_rs1;
  logic [NL*5-1:0]    out_rs2;
  logic [NL*3-1:0]    out_funct3;
  logic [NL*7-1:0]    out_funct7;
  logic [NL*XL-1:0]   out_imm;
  logic [NL*CW-1:0]   out_ctrl;
  logic [31:0]        decoded_count;

  decode_stage #(.NUM_LANES(NL), .XLEN(XL), .CTRL_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .decoded_count(decoded_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NL-1:0]    lv;
    logic [NL*XL-1:0] pc;
    logic [NL*5-1:0]  rd;
    logic [NL*5-1:0]  rs1;
    logic [NL*5-1:0]  rs2;
    logic [NL*3-1:0]  f3;
    logic [NL*7-1:0]  f7;
    logic [NL*XL-1:0] imm;
    logic [NL*CW-1:0] ctrl;
  } bundle_t;

  bundle_t     exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state: what the output slot should hold after each edge.
  bit          m_valid = 0;
  logic [NL-1:0] m_lanes = '0;
  logic [31:0] m_count = '0;
  bit          p_reset = 0, p_flush = 0, p_fire = 0, p_load = 0;
  logic [NL-1:0] p_lanes = '0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    s = $signed(w);
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return 32'(s >>> 20);
      7'b0100011: return 32'((s >>> 25) * 32) + 32'(w[11:7]);
      7'b1100011: return 32'((s >>> 31) * 4096) + 32'(w[7]) * 2048
                         + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
      7'b0110111, 7'b0010111: return w & 32'hFFFFF000;
      7'b1101111: return 32'((s >>> 31) * (1 << 20)) + 32'(w[19:12]) * 4096
                         + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [CW-1:0] ref_ctrl(input logic [31:0] w);
    logic [CW-1:0] c;
    case (w[6:0])
      7'b0110011: begin
        if (w[31:25] == 7'h00 || w[31:25] == 7'h20) c = 11'h011;
`ifdef DECODE_MULDIV_EN
        else if (w[31:25] == 7'h01) c = 11'h411;
`endif
        else c = 11'h200;
      end
      7'b0010011: c = 11'h01B;
      7'b0000011: c = 11'h063;
      7'b0100011: c = 11'h006;
      7'b1100011: c = 11'h088;
      7'b1101111: c = 11'h101;
      7'b1100111: c = 11'h103;
      7'b0110111, 7'b0010111: c = 11'h003;
      default: c = 11'h200;
    endcase
    if (w[11:7] == 5'd0) c = c & ~11'h001;
    return c;
  endfunction

  function automatic bundle_t expect_bundle(input logic [31:0] pc, input logic [NL*32-1:0] insts,
                                            input logic [NL-1:0] lv);
    bundle_t b;
    logic [31:0] w;
    b = '0;
    b.lv = lv;
    for (int i = 0; i < NL; i++) begin
      w = insts[32*i +: 32];
      b.pc[XL*i +: XL] = pc + 32'(4 * i);
      b.f3[3*i +: 3]   = w[14:12];
      b.f7[7*i +: 7]   = w[31:25];
      if (lv[i]) begin
        b.rd[5*i +: 5]    = w[11:7];
        b.rs1[5*i +: 5]   = w[19:15];
        b.rs2[5*i +: 5]   = w[24:20];
        b.imm[XL*i +: XL] = ref_imm(w);
        b.ctrl[CW*i +: CW] = ref_ctrl(w);
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops [9];
    logic [6:0] f7s [4];
    logic [31:0] w;
    int k;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h15};
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = ops[k];
    if (k == 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [NL*32-1:0] insts,
                               input logic [NL-1:0] lv, input logic ordy, input logic fl);
    in_valid      = v;
    in_pc         = pc;
    in_inst       = insts;
    in_lane_valid = lv;
    out_ready     = ordy;
    flush         = fl;
  endtask

  // Evaluate the handshake for the inputs just applied and queue any bundle that will load.
  task automatic commit();
    bit exp_rdy;
    #1;
    exp_rdy = reset_n && !flush && (!m_valid || out_ready);
    checkOutput("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
    p_reset = !reset_n;
    p_flush = flush;
    p_fire  = m_valid && out_ready && !flush;
    p_load  = in_valid && exp_rdy;
    p_lanes = in_lane_valid;
    if (p_load && |in_lane_valid) exp_q.push_back(expect_bundle(in_pc, in_inst, in_lane_valid));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (p_reset) begin
      m_valid = 0; m_lanes = '0; m_count = '0; exp_q.delete();
    end else if (p_flush) begin
      m_valid = 0;
    end else begin
      if (p_fire) m_count = m_count + 32'($countones(m_lanes));
      if (p_load) begin
        m_valid = |p_lanes;
        m_lanes = p_lanes;
      end else if (p_fire) m_valid = 0;
    end
    p_reset = 0; p_flush = 0; p_fire = 0; p_load = 0;
    checkOutput("out_valid", {127'b0, out_valid}, {127'b0, m_valid});
    checkOutput("decoded_count", 128'(decoded_count), 128'(m_count));
  endtask

  // Monitor: compare the held bundle whenever rename takes it; drop it on flush.
  always @(negedge clock) begin
    bundle_t e;
    if (reset_n && out_valid && (flush || out_ready)) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_underflow", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        if (!flush) begin
          checkOutput("out_lane_valid", 128'(out_lane_valid), 128'(e.lv));
          checkOutput("out_pc", 128'(out_pc), 128'(e.pc));
          checkOutput("out_rd", 128'(out_rd), 128'(e.rd));
          checkOutput("out_rs1", 128'(out_rs1), 128'(e.rs1));
          checkOutput("out_rs2", 128'(out_rs2), 128'(e.rs2));
          checkOutput("out_funct3", 128'(out_funct3), 128'(e.f3));
          checkOutput("out_funct7", 128'(out_funct7), 128'(e.f7));
          checkOutput("out_imm", 128'(out_imm), 128'(e.imm));
          checkOutput("out_ctrl", 128'(out_ctrl), 128'(e.ctrl));
        end
      end
    end
  end

  initial begin
    logic [CW-1:0] mul_ctrl;
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, '0, '0, 1'b0, 1'b0);
    commit(); step();
    commit(); step();
    checkOutput("reset_out_lane_valid", 128'(out_lane_valid), 128'(0));
    checkOutput("reset_out_pc", 128'(out_pc), 128'(0));
    checkOutput("reset_out_imm", 128'(out_imm), 128'(0));
    checkOutput("reset_out_ctrl", 128'(out_ctrl), 128'(0));
    reset_n = 1'b1;

    applyStimulus(1'b1, 32'h100, {32'hFFF00113, 32'h00500093}, 2'b11, 1'b1, 1'b0);
    commit(); step();
    checkOutput("addi_imm", 128'(out_imm), 128'({32'hFFFFFFFF, 32'h00000005}));
    checkOutput("addi_pc", 128'(out_pc), 128'({32'h104, 32'h100}));
    checkOutput("addi_ctrl", 128'(out_ctrl), 128'({11'h01B, 11'h01B}));

    applyStimulus(1'b1, 32'h200, {32'hFE0008E3, 32'hFE112E23}, 2'b11, 1'b1, 1'b0);
    commit(); step();
    checkOutput("sb_imm", 128'(out_imm), 128'({32'hFFFFFFF0, 32'hFFFFFFFC}));
    checkOutput("sb_ctrl", 128'(out_ctrl), 128'({11'h088, 11'h006}));

    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h300, {32'h00500093, 32'h00A00113}, 2'b11, 1'b0, 1'b0);
      commit(); step();
      checkOutput("hold_imm", 128'(out_imm), 128'({32'hFFFFFFF0, 32'hFFFFFFFC}));
    end
    applyStimulus(1'b1, 32'h300, {32'h00500093, 32'h00A00113}, 2'b11, 1'b1, 1'b0);
    commit(); step();
    checkOutput("hold_release_count", 128'(decoded_count), 128'(4));

    applyStimulus(1'b1, 32'h400, {32'h00500093, 32'h00A00113}, 2'b11, 1'b1, 1'b1);
    commit(); step();
    checkOutput("flush_count", 128'(decoded_count), 128'(4));

    applyStimulus(1'b1, 32'h500, {32'h00000000, 32'h00000033}, 2'b01, 1'b1, 1'b0);
    commit(); step();
    checkOutput("lane_inv_lv", 128'(out_lane_valid), 128'(2'b01));
    checkOutput("lane_inv_ctrl", 128'(out_ctrl), 128'({11'h000, 11'h010}));
    checkOutput("lane_inv_imm", 128'(out_imm), 128'(0));

    applyStimulus(1'b1, 32'h600, {32'h0000007F, 32'h02208033}, 2'b11, 1'b1, 1'b0);
    commit(); step();
`ifdef DECODE_MULDIV_EN
    mul_ctrl = 11'h410;
`else
    mul_ctrl = 11'h200;
`endif
    checkOutput("muldiv_ctrl", 128'(out_ctrl), 128'({11'h200, mul_ctrl}));
    checkOutput("lane_inv_count", 128'(decoded_count), 128'(5));

    for (int c = 0; c < 400; c++) begin
      logic [NL*32-1:0] insts;
      for (int l = 0; l < NL; l++) insts[32*l +: 32] = gen_inst();
      applyStimulus($urandom_range(0, 3) != 0, {$urandom, 2'b00} , insts,
                    NL'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      commit(); step();
    end

    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 32'h0, '0, '0, 1'b1, 1'b0);
      commit(); step();
    end
    checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised N-wide RV32I decode stage for the out-of-order core, sitting between fetch and rename.
- Each cycle it accepts a bundle of NUM_LANES instructions and decodes every lane's fields, sign-extended immediate and control word.
- The decoded bundle is held in a registered output slot with a valid/ready handshake, flush support and a decoded-instruction counter.

Parameters:
- NUM_LANES, 2, number of instructions decoded per cycle (1..8).
- XLEN, 32, data and PC width.
- CTRL_W, 11, control word width per lane (fixed layout below; do not override).

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- flush  in  1  discard held bundle; in_ready forced 0 that cycle
- in_valid  in  1  fetch bundle valid
- in_ready  out  1  stage can accept bundle
- in_pc  in  XLEN  PC of lane 0
- in_inst  in  NUM_LANES*32  lane i at [32i+31:32i]
- in_lane_valid  in  NUM_LANES  per-lane valid
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  rename accepts bundle
- out_lane_valid  out  NUM_LANES  registered lane valids
- out_pc  out  NUM_LANES*XLEN  per-lane PC
- out_rd, out_rs1, out_rs2  out  NUM_LANES*5 each  register specifiers
- out_funct3  out  NUM_LANES*3
- out_funct7  out  NUM_LANES*7
- out_imm  out  NUM_LANES*XLEN  sign-extended immediate
- out_ctrl  out  NUM_LANES*CTRL_W  control word
- decoded_count  out  32  number of lanes handed to rename

Behaviour:
- Reset (reset_n=0 at posedge): out_valid=0, every other out_* =0, decoded_count=0. Reset mid-transfer drops the held bundle.
- in_ready = reset_n && !flush && (!out_valid || out_ready). Combinational.
- Load: at posedge with in_valid && in_ready, register the full decode. Latency 1 cycle.
  - out_valid=1 if any in_lane_valid bit is set.
  - A bundle with all lanes invalid is consumed and does not set out_valid.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Drain: at posedge with out_valid && out_ready and no new load, out_valid goes to 0. Load and drain in the same cycle replace the bundle without a bubble.
- Flush: out_valid goes to 0 at the next posedge and no load occurs. Flush has priority over load. decoded_count does not increment.
- decoded_count increments by popcount(out_lane_valid) on every out_valid && out_ready && !flush edge. It wraps modulo 2^32.
- Lane PC: out_pc lane i = in_pc + 4*i, modulo 2^XLEN.
- Invalid lanes: imm, ctrl, rd, rs1 and rs2 are forced to 0.
- Field slices: rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- Immediates are sign-extended from inst[31]:
  - I: load, OP-IMM, JALR.
  - S: store.
  - B: branch, bit0=0.
  - U: LUI, AUIPC, low 12 bits zero.
  - J: JAL, bit0=0.
  - R-type and illegal: 0.
- out_ctrl bit layout:
  - [0] reg_write, [1] alu_src, [2] mem_write, [4:3] alu_op, [5] mem_to_reg, [6] mem_read, [7] branch, [8] jump, [9] illegal, [10] muldiv.
- Control words by opcode:
  - R 0110011: reg_write, alu_op=10.
  - OP-IMM 0010011: reg_write, alu_src, alu_op=11.
  - LOAD 0000011: reg_write, alu_src, mem_read, mem_to_reg, alu_op=00.
  - STORE 0100011: alu_src, mem_write, alu_op=00.
  - BRANCH 1100011: branch, alu_op=01.
  - JAL 1101111: reg_write, jump.
  - JALR 1100111: reg_write, jump, alu_src.
  - LUI 0110111 and AUIPC 0010111: reg_write, alu_src, alu_op=00.
  - Any other opcode: illegal=1, all other bits 0.
- reg_write is forced 0 when rd==0.
- R-type with funct7 other than 0000000 or 0100000 is illegal, except as described under Optional Feature.

Optional Feature:
- Macro: DECODE_MULDIV_EN.
- Defined: R-type with funct7=0000001 decodes as reg_write=1, alu_op=10, muldiv=1.
- Undefined: the same encoding is illegal=1; ctrl bit 10 is always 0.

Test Plan:
- Reset, then bundle lane0=0x00500093 (addi x1,x0,5), lane1=0xFFF00113 (addi x2,x0,-1), in_pc=0x100, both valid -> next cycle out_valid=1; imm 0x5 and 0xFFFFFFFF; out_pc 0x100 and 0x104; ctrl 0x01B on both lanes.
- Store 0xFE112E23 (sw x1,-4(x2)) and branch 0xFE0008E3 (beq x0,x0,-16) -> imm 0xFFFFFFFC with ctrl 0x006; imm 0xFFFFFFF0 with ctrl 0x088.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; raise out_ready -> new bundle loads the same edge, decoded_count +2.
- Assert flush while out_valid=1 -> out_valid=0 next cycle; decoded_count unchanged; in_ready=0 during the flush cycle.
- Lane1 invalid, lane0=0x00000033 (add x0,x0,x0) -> out_lane_valid=01; lane0 reg_write=0; lane1 fields all 0; count +1.
- 0x02208033 (mul x0,x1,x2 with rd=x0) and 0x0000007F -> muldiv=1 (or illegal=1 without DECODE_MULDIV_EN); 0x7F gives illegal=1 with all other ctrl bits 0.
